// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hexadecimal seven-segment driver for an
// N-digit common-segment display. A load strobe captures the value into a
// shadow register, and the shadow becomes active only at a frame boundary, so
// a scan frame never mixes old and new digits. The driver also supports
// leading-zero blanking and a frame-counted blink.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_load       single-cycle strobe that captures i_value
//   i_value      NUM_DIGITS hex nibbles; digit 0 is bits [3:0]
//   i_blank_lz   enable leading-zero blanking
//   i_blink_en   enable blinking
//   o_seg_n      active-low segments {g,f,e,d,c,b,a}, registered
//   o_dig_sel_n  active-low one-hot digit enable, registered
//   o_pending    a loaded value is waiting for the frame boundary
//   o_frame_tick high on the last cycle of each scan frame
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_blank_lz,
    input  logic                    i_blink_en,
    output logic [6:0]              o_seg_n,
    output logic [NUM_DIGITS-1:0]   o_dig_sel_n,
    output logic                    o_pending,
    output logic                    o_frame_tick
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    logic [SCAN_W-1:0]       r_scan_cnt,  w_scan_next;
    logic [DIG_W-1:0]        r_digit_idx, w_digit_next;
    logic [BLINK_W-1:0]      r_blink_cnt, w_blink_next;
    logic                    r_phase,     w_phase_next;
    logic [4*NUM_DIGITS-1:0] r_active,    w_active_next;
    logic [4*NUM_DIGITS-1:0] r_shadow,    w_shadow_next;
    logic                    r_pending,   w_pending_next;
    logic [6:0]              r_seg_n,     w_seg_next;
    logic [NUM_DIGITS-1:0]   r_dig_sel_n, w_dig_sel_next;

    logic                    w_scan_last;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_blank;

    assign w_scan_last = (r_scan_cnt == SCAN_LAST);
    assign w_boundary  = w_scan_last && (r_digit_idx == DIG_LAST);

    // Scan, blink and load/commit next state.
    always_comb begin
        w_scan_next    = w_scan_last ? '0 : r_scan_cnt + 1'b1;
        w_digit_next   = r_digit_idx;
        w_blink_next   = r_blink_cnt;
        w_phase_next   = r_phase;
        w_active_next  = r_active;
        w_shadow_next  = r_shadow;
        w_pending_next = r_pending;

        if (w_scan_last) begin
            w_digit_next = (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
        end

        if (w_boundary) begin
            if (r_blink_cnt == BLINK_LAST) begin
                w_blink_next = '0;
                w_phase_next = ~r_phase;
            end else begin
                w_blink_next = r_blink_cnt + 1'b1;
            end
            // A load landing on the boundary wins over any stale shadow.
            if (i_load) begin
                w_active_next  = i_value;
                w_pending_next = 1'b0;
            end else if (r_pending) begin
                w_active_next  = r_shadow;
                w_pending_next = 1'b0;
            end
        end else if (i_load) begin
            w_shadow_next  = i_value;
            w_pending_next = 1'b1;
        end
    end

    // Leading-zero mask: walk from the most significant digit down while zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        w_blank  = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run = zero_run & (r_active[4*k +: 4] == 4'h0);
            if (k != 0) begin
                w_blank[k] = zero_run;
            end
        end
    end

    // Current digit selection and registered output values.
    always_comb begin
        w_cur_nib      = 4'h0;
        w_cur_blank    = 1'b0;
        w_dig_sel_next = '1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (r_digit_idx == DIG_W'(k)) begin
                w_cur_nib         = r_active[4*k +: 4];
                w_cur_blank       = w_blank[k];
                w_dig_sel_next[k] = 1'b0;
            end
        end
        if ((i_blink_en && !r_phase) || (i_blank_lz && w_cur_blank)) begin
            w_seg_next = 7'h7F;
        end else begin
            w_seg_next = seg_code(w_cur_nib);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_active    <= '0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            r_seg_n     <= 7'h7F;
            r_dig_sel_n <= '1;
        end else begin
            r_scan_cnt  <= w_scan_next;
            r_digit_idx <= w_digit_next;
            r_blink_cnt <= w_blink_next;
            r_phase     <= w_phase_next;
            r_active    <= w_active_next;
            r_shadow    <= w_shadow_next;
            r_pending   <= w_pending_next;
            r_seg_n     <= w_seg_next;
            r_dig_sel_n <= w_dig_sel_next;
        end
    end

    assign o_seg_n      = r_seg_n;
    assign o_dig_sel_n  = r_dig_sel_n;
    assign o_pending    = r_pending;
    // Gated so the tick stays low while reset is held.
    assign o_frame_tick = w_boundary & i_rst_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_FRAMES=2 (16-cycle frames). cyc counts cycles after the last reset
// edge; cycle 15 of each frame is the boundary. Registered outputs seen in
// cycle c reflect state of cycle c-1.
module tb_seg7_scan_driver;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_load;
    logic [15:0] i_value;
    logic        i_blank_lz;
    logic        i_blink_en;
    logic [6:0]  o_seg_n;
    logic [3:0]  o_dig_sel_n;
    logic        o_pending;
    logic        o_frame_tick;

    int checks;
    int failures;
    int cyc;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (i_load),
        .i_value      (i_value),
        .i_blank_lz   (i_blank_lz),
        .i_blink_en   (i_blink_en),
        .o_seg_n      (o_seg_n),
        .o_dig_sel_n  (o_dig_sel_n),
        .o_pending    (o_pending),
        .o_frame_tick (o_frame_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_load  = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_load  = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        checks++;
        if (o_seg_n !== 7'h7F) begin
            failures++;
            $display("FAIL reset_seg: got %h want 7f", o_seg_n);
        end
        checks++;
        if (o_dig_sel_n !== 4'hF) begin
            failures++;
            $display("FAIL reset_dig: got %b want 1111", o_dig_sel_n);
        end
        checks++;
        if (o_pending !== 1'b0 || o_frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got pending=%b tick=%b want 0 0", o_pending, o_frame_tick);
        end
        i_rst_n = 1'b1;
        cyc     = 0;
        step();
        checks++;
        if (o_seg_n !== 7'h40 || o_dig_sel_n !== 4'b1110) begin
            failures++;
            $display("FAIL reset_first: got seg=%h dig=%b want 40 1110", o_seg_n, o_dig_sel_n);
        end
    endtask

    task automatic test_boundary_load();
        logic [6:0] exp_seg [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};
        logic [3:0] exp_dig;
        do_reset();
        goto(14);
        checks++;
        if (o_frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL t1_tick_c14: got %b want 0", o_frame_tick);
        end
        step();
        checks++;
        if (o_frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL t1_tick_c15: got %b want 1", o_frame_tick);
        end
        i_value = 16'h1A3F;
        i_load  = 1'b1;
        step();
        i_load = 1'b0;
        checks++;
        if (o_pending !== 1'b0) begin
            failures++;
            $display("FAIL t1_pending: got %b want 0", o_pending);
        end
        for (int d = 0; d < 4; d++) begin
            goto(17 + 4 * d);
            exp_dig    = 4'hF;
            exp_dig[d] = 1'b0;
            checks++;
            if (o_seg_n !== exp_seg[d] || o_dig_sel_n !== exp_dig) begin
                failures++;
                $display("FAIL t1_digit%0d: got seg=%h dig=%b want %h %b",
                         d, o_seg_n, o_dig_sel_n, exp_seg[d], exp_dig);
            end
        end
    endtask

    task automatic test_pending_load();
        logic [6:0] exp_seg [4] = '{7'h78, 7'h40, 7'h40, 7'h40};
        do_reset();
        goto(5);
        i_value = 16'h0007;
        i_load  = 1'b1;
        step();
        i_load = 1'b0;
        checks++;
        if (o_pending !== 1'b1) begin
            failures++;
            $display("FAIL t2_pending_set: got %b want 1", o_pending);
        end
        goto(15);
        checks++;
        if (o_pending !== 1'b1) begin
            failures++;
            $display("FAIL t2_pending_hold: got %b want 1", o_pending);
        end
        step();
        checks++;
        if (o_pending !== 1'b0 || o_seg_n !== 7'h40 || o_dig_sel_n !== 4'b0111) begin
            failures++;
            $display("FAIL t2_old_tail: got pending=%b seg=%h dig=%b want 0 40 0111",
                     o_pending, o_seg_n, o_dig_sel_n);
        end
        for (int d = 0; d < 4; d++) begin
            goto(17 + 4 * d);
            checks++;
            if (o_seg_n !== exp_seg[d]) begin
                failures++;
                $display("FAIL t2_digit%0d: got %h want %h", d, o_seg_n, exp_seg[d]);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] exp_zero [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        logic [6:0] exp_seven [4] = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
        i_blank_lz = 1'b1;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            goto(1 + 4 * d);
            checks++;
            if (o_seg_n !== exp_zero[d]) begin
                failures++;
                $display("FAIL t3_zero_digit%0d: got %h want %h", d, o_seg_n, exp_zero[d]);
            end
        end
        goto(15);
        i_value = 16'h0007;
        i_load  = 1'b1;
        step();
        i_load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            goto(17 + 4 * d);
            checks++;
            if (o_seg_n !== exp_seven[d]) begin
                failures++;
                $display("FAIL t3_seven_digit%0d: got %h want %h", d, o_seg_n, exp_seven[d]);
            end
        end
        i_blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seg;
        do_reset();
        goto(3);
        i_value = 16'h1111;
        i_load  = 1'b1;
        step();
        i_load = 1'b0;
        goto(8);
        i_value = 16'h2222;
        i_load  = 1'b1;
        step();
        i_load = 1'b0;
        while (cyc < 33) begin
            exp_seg = (cyc <= 16) ? 7'h40 : 7'h24;
            checks++;
            if (o_seg_n !== exp_seg) begin
                failures++;
                $display("FAIL t4_seg_c%0d: got %h want %h", cyc, o_seg_n, exp_seg);
            end
            step();
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_seg;
        logic [3:0] exp_dig;
        logic       exp_tick;
        int         fr;
        i_blink_en = 1'b1;
        do_reset();
        step();
        while (cyc <= 96) begin
            fr         = (cyc - 1) / 16;
            exp_seg    = (fr == 2 || fr == 3) ? 7'h7F : 7'h40;
            exp_dig    = 4'hF;
            exp_dig[((cyc - 1) / 4) % 4] = 1'b0;
            exp_tick   = (cyc % 16 == 15);
            checks++;
            if (o_seg_n !== exp_seg) begin
                failures++;
                $display("FAIL t5_seg_c%0d: got %h want %h", cyc, o_seg_n, exp_seg);
            end
            checks++;
            if (o_dig_sel_n !== exp_dig) begin
                failures++;
                $display("FAIL t5_dig_c%0d: got %b want %b", cyc, o_dig_sel_n, exp_dig);
            end
            checks++;
            if (o_frame_tick !== exp_tick) begin
                failures++;
                $display("FAIL t5_tick_c%0d: got %b want %b", cyc, o_frame_tick, exp_tick);
            end
            step();
        end
        i_blink_en = 1'b0;
    endtask

    task automatic test_reset_pending();
        logic [3:0] exp_dig;
        do_reset();
        goto(5);
        i_value = 16'h5555;
        i_load  = 1'b1;
        step();
        i_load = 1'b0;
        goto(9);
        checks++;
        if (o_pending !== 1'b1) begin
            failures++;
            $display("FAIL t6_pending_pre: got %b want 1", o_pending);
        end
        i_rst_n = 1'b0;
        step();
        checks++;
        if (o_seg_n !== 7'h7F || o_dig_sel_n !== 4'hF || o_pending !== 1'b0
            || o_frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL t6_reset_vals: got seg=%h dig=%b pend=%b tick=%b want 7f 1111 0 0",
                     o_seg_n, o_dig_sel_n, o_pending, o_frame_tick);
        end
        i_rst_n = 1'b1;
        cyc     = 0;
        step();
        while (cyc <= 40) begin
            exp_dig = 4'hF;
            exp_dig[((cyc - 1) / 4) % 4] = 1'b0;
            checks++;
            if (o_seg_n !== 7'h40 || o_dig_sel_n !== exp_dig) begin
                failures++;
                $display("FAIL t6_restart_c%0d: got seg=%h dig=%b want 40 %b",
                         cyc, o_seg_n, o_dig_sel_n, exp_dig);
            end
            step();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        i_rst_n    = 1'b0;
        i_load     = 1'b0;
        i_value    = 16'h0000;
        i_blank_lz = 1'b0;
        i_blink_en = 1'b0;
        test_reset();
        test_boundary_load();
        test_pending_load();
        test_blank_lz();
        test_back_to_back();
        test_blink();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed hexadecimal seven-segment driver for an N-digit common-segment display. Latches an N-nibble value through a load strobe and scans one digit at a time through shared active-low segment lines. Adds tear-free frame-boundary updates, leading-zero blanking and blinking. Replaces the per-digit combinational decoders at the board display boundary.

## Interface
- NUM_DIGITS, 4, digit count; legal range 1..8.
- SCAN_DIV, 1000, clock cycles each digit is driven; must be ≥ 1.
- BLINK_FRAMES, 250, scan frames per blink half-period; must be ≥ 1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  single-cycle strobe; captures value.
- value  in  4*NUM_DIGITS  hex digits; digit 0 is bits [3:0], the least significant.
- blank_lz  in  1  enables leading-zero blanking.
- blink_en  in  1  enables blinking.
- seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dig_sel_n  out  NUM_DIGITS  active-low one-hot digit enable.
- pending  out  1  a loaded value is waiting for the frame boundary.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Segment code, active-low: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, B=03h, C=46h, D=21h, E=06h, F=0Eh. Blank is 7Fh.
- State registers:
  - scan_cnt: 0..SCAN_DIV-1.
  - digit_idx: 0..NUM_DIGITS-1.
  - active and shadow: 4*NUM_DIGITS bits each.
  - pending.
  - blink_cnt: 0..BLINK_FRAMES-1.
  - phase: 1 means visible.
- Scan:
  - scan_cnt increments every cycle.
  - At SCAN_DIV-1, scan_cnt wraps to 0 and digit_idx advances, wrapping NUM_DIGITS-1 → 0.
- Boundary cycle: scan_cnt==SCAN_DIV-1 and digit_idx==NUM_DIGITS-1. frame_tick=1 on this cycle only.
- Load rules:
  - Load off a boundary cycle: shadow←value, pending←1.
  - Repeat load while pending: newest value overwrites shadow.
  - Boundary cycle with pending=1 and no load: active←shadow, pending←0.
  - Load on a boundary cycle: active←value directly, pending stays/becomes 0, and shadow is discarded.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked if it and every more-significant digit of active are 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Blink:
  - On each boundary cycle blink_cnt increments.
  - At BLINK_FRAMES-1, blink_cnt wraps and phase toggles.
  - blink_cnt and phase run regardless of blink_en.
- Displayed code:
  - If blink_en=1 and phase=0, seg_n=7Fh.
  - Otherwise seg_n=7Fh for a digit blanked by the leading-zero rule, else the segment code of active[digit_idx].
- dig_sel_n: bit digit_idx low, all other bits high. It stays driven during blink-off and blanking.

## Timing
- Outputs are registered. seg_n and dig_sel_n in cycle t+1 reflect digit_idx, active, phase, blank_lz and blink_en sampled in cycle t.
- Reset while rst_n=0 at an edge:
  - scan_cnt=0, digit_idx=0, blink_cnt=0, phase=1.
  - active=0, shadow=0, pending=0.
  - seg_n=7Fh, dig_sel_n=all ones, frame_tick=0.
- First edge after reset release: dig_sel_n=~1 and seg_n=40h, i.e. digit 0 showing "0".
- Reset mid-frame or mid-pending discards shadow and active; no partial commit.
- Load latency:
  - New active value first appears on seg_n for digit 0 of the next frame, one cycle after the boundary edge.
  - pending is visible the cycle after load and clears on the boundary edge.
- SCAN_DIV=1: digit advances every cycle; every cycle with digit_idx=NUM_DIGITS-1 is a boundary cycle.
- NUM_DIGITS=1: every scan_cnt wrap is a boundary; dig_sel_n is constantly 0 after reset.
- frame_tick is combinational from registered state: high exactly on the boundary cycle, and 0 during reset.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, so one frame is 16 cycles.
1. Reset, then load value=16'h1A3F on the boundary cycle → pending stays 0. Next frame shows digit-by-digit F=0Eh, 3=30h, A=08h, 1=79h, each for 4 cycles, with dig_sel_n 1110, 1101, 1011, 0111.
2. Load 16'h0007 at frame cycle 5 → pending=1 until the boundary, then 0. The old digits complete the current frame; the next frame shows 78h, 40h, 40h, 40h.
3. Same value 16'h0007 with blank_lz=1 → next frame shows 78h, 7Fh, 7Fh, 7Fh. Value 16'h0000 with blank_lz=1 → 40h, 7Fh, 7Fh, 7Fh.
4. Two loads in one frame (16'h1111 then 16'h2222) → only 16'h2222 is ever displayed: 24h on all digits.
5. blink_en=1 from reset → frames 0–1 visible, frames 2–3 seg_n=7Fh with dig_sel_n still scanning, frames 4–5 visible. frame_tick pulses every 16 cycles.
6. Assert rst_n=0 for one edge while pending=1 at frame cycle 9 → all outputs are at their reset values the next cycle, the loaded value is never displayed, and the display restarts at digit 0 showing "0".
